// File: rtl/bcd_arb_pkg.sv
// Shared definitions for the BCD converter arbiter: state encoding,
// BCD range limits and the requester-index width helper.
package bcd_arb_pkg;

    // One-hot state encoding, one bit per FSM state.
    localparam logic [5:0] ST_IDLE    = 6'b000001;
    localparam logic [5:0] ST_LOAD    = 6'b000010;
    localparam logic [5:0] ST_START   = 6'b000100;
    localparam logic [5:0] ST_WAIT    = 6'b001000;
    localparam logic [5:0] ST_CAPTURE = 6'b010000;
    localparam logic [5:0] ST_RESP    = 6'b100000;

    typedef enum logic [5:0] {
        S_IDLE    = ST_IDLE,
        S_LOAD    = ST_LOAD,
        S_START   = ST_START,
        S_WAIT    = ST_WAIT,
        S_CAPTURE = ST_CAPTURE,
        S_RESP    = ST_RESP
    } state_t;

    // Largest operand the 4-digit converter can represent, and the
    // saturated digit pattern returned for anything above it.
    localparam int unsigned BCD_MAX = 9999;
    localparam logic [15:0] BCD_SAT = 16'h9999;

    // Width of a requester index; at least one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bcd_conv_arbiter_if.sv
// Request/response bus between the clients and the arbiter.
// master = client side, slave = arbiter side.
interface bcd_conv_arbiter_if import bcd_arb_pkg::*; #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16
);
    localparam int ID_W = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          rsp_valid;
    logic [ID_W-1:0]               rsp_id;
    logic [15:0]                   rsp_bcd;
    logic                          rsp_ovf;
    logic                          rsp_err;

    modport master (
        output req_valid, req_data,
        input  req_ready, rsp_valid, rsp_id, rsp_bcd, rsp_ovf, rsp_err
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, rsp_valid, rsp_id, rsp_bcd, rsp_ovf, rsp_err
    );

endinterface

// File: rtl/bcd_conv_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first active request strictly after
// last_grant, wrapping around. The pointer register lives in the parent.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);

    logic [ID_W-1:0] cand;
    logic            found;

    // Scan offsets 1..NUM_REQ from the pointer; the first hit wins.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path
        // leaves a value unassigned, which would infer a latch.
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = ID_W'((int'(last_grant) + off) % NUM_REQ);
            if (en && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Shares one binary-to-BCD converter among NUM_REQ requesters. Grants
// round-robin, sequences the converter handshake, screens operands above
// 9999 without touching the converter, and aborts after TIMEOUT cycles.
module bcd_conv_arbiter import bcd_arb_pkg::*; #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bcd_conv_arbiter_if.slave     bus,
    output logic                  busy,
    output logic                  conv_en,
    output logic [DATA_WIDTH-1:0] conv_data,
    input  logic                  conv_done,
    input  logic [15:0]           conv_bcd
);

    localparam int ID_W  = id_width(NUM_REQ);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t                state;
    logic [DATA_WIDTH-1:0] op_reg;
    logic [ID_W-1:0]       id_reg;
    logic [ID_W-1:0]       last_grant;
    logic [CNT_W-1:0]      wait_cnt;

    logic [NUM_REQ-1:0]    req_ready_q;
    logic                  rsp_valid_q;
    logic [ID_W-1:0]       rsp_id_q;
    logic [15:0]           rsp_bcd_q;
    logic                  rsp_ovf_q;
    logic                  rsp_err_q;
    logic                  busy_q;
    logic                  conv_en_q;

    logic [NUM_REQ-1:0]    grant;
    logic [ID_W-1:0]       gnt_idx;
    logic                  gnt_any;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_over;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req        (bus.req_valid),
        .last_grant (last_grant),
        .en         (state == S_IDLE),
        .grant      (grant),
        .idx        (gnt_idx)
    );

    assign gnt_any  = |grant;
    assign sel_data = bus.req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    assign sel_over = (32'(sel_data) > BCD_MAX);

    // The operand register only loads in IDLE, so the converter sees a
    // stable value for the whole transaction.
    assign conv_data = op_reg;
    assign conv_en   = conv_en_q;
    assign busy      = busy_q;

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_bcd   = rsp_bcd_q;
    assign bus.rsp_ovf   = rsp_ovf_q;
    assign bus.rsp_err   = rsp_err_q;

    // Transaction sequencer with registered outputs; pulses default low.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge (synchronous), and all
        // state uses non-blocking assignment so every register updates
        // from pre-edge values.
        if (!rst_n) begin
            state       <= S_IDLE;
            op_reg      <= '0;
            id_reg      <= '0;
            last_grant  <= ID_W'(NUM_REQ - 1);
            wait_cnt    <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_bcd_q   <= '0;
            rsp_ovf_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            conv_en_q   <= 1'b0;
        end else begin
            req_ready_q <= '0;
            rsp_valid_q <= 1'b0;
            conv_en_q   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (gnt_any) begin
                        req_ready_q <= grant;
                        op_reg      <= sel_data;
                        id_reg      <= gnt_idx;
                        last_grant  <= gnt_idx;
                        busy_q      <= 1'b1;
                        if (sel_over) begin
                            state       <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_id_q    <= gnt_idx;
                            rsp_bcd_q   <= BCD_SAT;
                            rsp_ovf_q   <= 1'b1;
                            rsp_err_q   <= 1'b0;
                        end else begin
                            state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    state     <= S_START;
                    conv_en_q <= 1'b1;
                end
                S_START: begin
                    state    <= S_WAIT;
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    if (conv_done) begin
                        state <= S_CAPTURE;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state       <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= id_reg;
                        rsp_bcd_q   <= '0;
                        rsp_ovf_q   <= 1'b0;
                        rsp_err_q   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    // Converter digits settle the cycle after tran_done.
                    state       <= S_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_id_q    <= id_reg;
                    rsp_bcd_q   <= conv_bcd;
                    rsp_ovf_q   <= 1'b0;
                    rsp_err_q   <= 1'b0;
                end
                S_RESP: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
